// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register file's single write port, with a
// pending-write scoreboard that decode uses for RAW hazard detection.
module regfile_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                 clk_in,
    input  logic                 reset_n_in,
    input  logic                 a_valid_in,
    output logic                 a_ready_out,
    input  logic [ADDR_W-1:0]    a_addr_in,
    input  logic [DATA_W-1:0]    a_data_in,
    input  logic                 b_valid_in,
    output logic                 b_ready_out,
    input  logic [ADDR_W-1:0]    b_addr_in,
    input  logic [DATA_W-1:0]    b_data_in,
    input  logic                 rsv_valid_in,
    input  logic [ADDR_W-1:0]    rsv_addr_in,
    input  logic [ADDR_W-1:0]    rs_in,
    input  logic [ADDR_W-1:0]    rt_in,
    output logic                 rs_busy_out,
    output logic                 rt_busy_out,
    output logic [ADDR_W-1:0]    write_addr_out,
    output logic [DATA_W-1:0]    write_data_out,
    output logic                 regWrite_out,
    output logic [2**ADDR_W-1:0] pending_out
);

    localparam int NREG = 2**ADDR_W;

    logic              last_b_reg;
    logic              last_b_next;
    logic [NREG-1:0]   pending_reg;
    logic [NREG-1:0]   pending_next;
    logic [ADDR_W-1:0] write_addr_reg;
    logic [DATA_W-1:0] write_data_reg;
    logic              regwrite_reg;

    logic              grant_a;
    logic              grant_b;
    logic              grant_any;
    logic [ADDR_W-1:0] grant_addr;
    logic [DATA_W-1:0] grant_data;

    // Round-robin: on a tie, the requester not granted last wins.
    always_comb begin
        grant_a     = 1'b0;
        grant_b     = 1'b0;
        last_b_next = last_b_reg;
        if (a_valid_in && (!b_valid_in || last_b_reg)) begin
            grant_a     = 1'b1;
            last_b_next = 1'b0;
        end else if (b_valid_in) begin
            grant_b     = 1'b1;
            last_b_next = 1'b1;
        end
    end

    assign grant_any  = grant_a | grant_b;
    assign grant_addr = grant_a ? a_addr_in : b_addr_in;
    assign grant_data = grant_a ? a_data_in : b_data_in;

    // A new reservation beats the clearing write of an older producer.
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_pending
            if (gi == 0) begin : g_zero
                assign pending_next[gi] = 1'b0;
            end else begin : g_entry
                assign pending_next[gi] =
                    (rsv_valid_in && rsv_addr_in == ADDR_W'(gi)) ? 1'b1 :
                    (grant_any && grant_addr == ADDR_W'(gi))     ? 1'b0 :
                    pending_reg[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            last_b_reg     <= 1'b1;
            pending_reg    <= '0;
            write_addr_reg <= '0;
            write_data_reg <= '0;
            regwrite_reg   <= 1'b0;
        end else begin
            last_b_reg   <= last_b_next;
            pending_reg  <= pending_next;
            regwrite_reg <= grant_any && (grant_addr != '0);
            if (grant_any) begin
                write_addr_reg <= grant_addr;
                write_data_reg <= grant_data;
            end
        end
    end

    // The in-flight term covers the one cycle where the scoreboard bit has
    // cleared but the register file has not yet absorbed the write.
    assign rs_busy_out = (rs_in != '0) &&
                         (pending_reg[rs_in] || (regwrite_reg && write_addr_reg == rs_in));
    assign rt_busy_out = (rt_in != '0) &&
                         (pending_reg[rt_in] || (regwrite_reg && write_addr_reg == rt_in));

    assign a_ready_out    = grant_a;
    assign b_ready_out    = grant_b;
    assign write_addr_out = write_addr_reg;
    assign write_data_out = write_data_reg;
    assign regWrite_out   = regwrite_reg;
    assign pending_out    = pending_reg;

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters. Requester A is the ALU writeback path; requester B is the load / multiply-divide writeback path.
- Keeps a 32-entry pending-write scoreboard so decode can detect RAW hazards on rs/rt.
- Sits between the writeback stage and the register file; drives the register file's write_addr_in / write_data_in / regWrite_in.

Parameters:
DATA_W, 32, width of register data
ADDR_W, 5, width of register address (NREG = 2**ADDR_W)

Ports:
clk_in  input  1  clock, rising edge
reset_n_in  input  1  reset, asynchronous, active-low
a_valid_in  input  1  requester A has a write
a_ready_out  output  1  requester A write accepted this cycle
a_addr_in  input  ADDR_W  requester A destination register
a_data_in  input  DATA_W  requester A write data
b_valid_in  input  1  requester B has a write
b_ready_out  output  1  requester B write accepted this cycle
b_addr_in  input  ADDR_W  requester B destination register
b_data_in  input  DATA_W  requester B write data
rsv_valid_in  input  1  issue stage reserves a destination
rsv_addr_in  input  ADDR_W  reserved destination register
rs_in  input  ADDR_W  decode source register rs
rt_in  input  ADDR_W  decode source register rt
rs_busy_out  output  1  rs has an outstanding write
rt_busy_out  output  1  rt has an outstanding write
write_addr_out  output  ADDR_W  to register file write_addr_in
write_data_out  output  DATA_W  to register file write_data_in
regWrite_out  output  1  to register file regWrite_in
pending_out  output  2**ADDR_W  scoreboard bit vector

Behaviour:
- Reset (async, reset_n_in=0):
  - regWrite_out=0, write_addr_out=0, write_data_out=0, pending=0.
  - Last-grant pointer=B, so A wins the first tie.
  - Any in-flight write is dropped.
- Handshake:
  - A transfer occurs when valid and ready are both high in the same cycle.
  - ready is combinational from the current valids and the pointer. No ready without valid.
  - Requesters hold valid/addr/data stable until ready; the arbiter has no request buffer.
- Arbitration:
  - Only one valid: grant it.
  - Both valid: grant the requester not granted last (round-robin). The pointer updates only on a grant.
  - At most one ready high per cycle.
- Output path (registered, latency 1):
  - At the edge ending a grant cycle: write_addr_out/write_data_out load the granted addr/data; regWrite_out=1 if addr!=0.
  - No grant: regWrite_out=0, addr/data hold their previous values.
  - With both valid continuously, regWrite_out is high every cycle, alternating A,B.
- Address 0:
  - The request is granted and consumes its turn (pointer advances).
  - regWrite_out stays 0; the scoreboard is unaffected.
- Scoreboard:
  - pending[i] sets at the edge when rsv_valid_in=1 and rsv_addr_in=i, i!=0.
  - pending[i] clears at the edge of a grant with addr=i.
  - Set and clear of the same i in the same cycle: set wins (a new producer was issued).
  - Reserving an already-pending register: stays 1. Granted write with no reservation: clear is a no-op.
  - pending[0] is always 0.
- Busy outputs (combinational):
  - rs_busy_out = (rs_in!=0) & (pending[rs_in] | (regWrite_out & write_addr_out==rs_in)). The second term covers the write in flight to the register file.
  - rt_busy_out is the same with rt_in.
- pending_out is a direct register output.

Test Plan:
1. Release reset. Set A(addr 3, data 100) and B(addr 6, data 200) both valid → cycle 0: a_ready=1. Next cycle: regWrite_out=1, addr 3, data 100, and b_ready=1. Following cycle: addr 6, data 200.
2. Hold A and B valid 4 cycles → grants A,B,A,B; regWrite_out high 4 consecutive cycles; pointer ends at B.
3. A valid with addr 0, data 100 → a_ready=1, regWrite_out stays 0, pending unchanged; a subsequent tie grants B.
4. rsv addr 5, then rs_in=5 → rs_busy_out=1 and pending_out[5]=1. A writes addr 5 → after the grant edge, pending[5]=0 but rs_busy_out=1 for one cycle (in flight), then 0.
5. Same cycle: rsv_addr 7 plus grant B addr 7, with pending[7]=1 beforehand → pending[7] remains 1; rt_in=7 keeps rt_busy_out=1.
6. Assert reset_n_in=0 mid-stream with regWrite_out=1 and pending=0x48 → regWrite_out, addr, data and pending go to 0 immediately without a clock; after release, the first tie grants A.
